// File: rtl/pipe_fwd_ctrl_pkg.sv
// Shared pipeline definitions: ALU operand select encodings, link register,
// and the shadow-stage records tracked by the forwarding controller.
package pipe_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_REG    = 2'b00,
    SEL_SA_IMM = 2'b01,
    SEL_MALU   = 2'b10,
    SEL_WALU   = 2'b11
  } sel_t;

  localparam logic [4:0] RA    = 5'd31;
  localparam int         CNT_W = 16;

  // EXE shadow keeps the load flag because only an EXE-stage load forces a stall
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } shadow_t;

  // By MEM the load result is reachable through the WB path, so only the write tag matters
  typedef struct packed {
    logic       wreg;
    logic [4:0] rn;
  } fwd_t;

  localparam shadow_t E_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, rn: 5'd0};
  localparam fwd_t    M_BUBBLE = '{wreg: 1'b0, rn: 5'd0};

  function automatic logic [4:0] eff_dest(input logic jal, input logic [4:0] rn);
    return jal ? RA : rn;
  endfunction

endpackage

// File: rtl/pipe_fwd_ctrl_if.sv
// ID-stage decode bundle into the forwarding controller and its EXE-side
// select/stall results.
interface pipe_fwd_ctrl_if;
  import pipe_fwd_ctrl_pkg::*;

  logic [4:0]       drs;
  logic [4:0]       drt;
  logic             duse_rs;
  logic             duse_rt;
  logic             dshift;
  logic             daluimm;
  logic             dwreg;
  logic             dm2reg;
  logic             djal;
  logic [4:0]       drn;
  logic             dvalid;
  logic             dflush;
  logic             stall;
  logic [1:0]       adepend;
  logic [1:0]       bdepend;
  logic             ebubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output drs, drt, duse_rs, duse_rt, dshift, daluimm, dwreg, dm2reg, djal, drn,
           dvalid, dflush,
    input  stall, adepend, bdepend, ebubble, stall_cnt
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dshift, daluimm, dwreg, dm2reg, djal, drn,
           dvalid, dflush,
    output stall, adepend, bdepend, ebubble, stall_cnt
  );

endinterface

// File: rtl/pipe_fwd_ctrl_fwd_sel.sv
// One ALU operand select: override first, then the youngest in-flight producer
// (EXE before MEM). Also flags a load in EXE that this operand depends on.
module fwd_sel
  import pipe_fwd_ctrl_pkg::*;
(
  input  logic       [4:0] src,
  input  logic             use_src,
  input  logic             override,
  input  shadow_t          e,
  input  fwd_t             m,
  output sel_t             sel,
  output logic             load_hit
);

  logic hit_e;
  logic hit_m;

  // r0 is hard-wired zero, so it never matches a producer
  assign hit_e    = use_src && (src != 5'd0) && e.wreg && (src == e.rn);
  assign hit_m    = use_src && (src != 5'd0) && m.wreg && (src == m.rn);
  assign load_hit = hit_e && e.m2reg;

  always_comb begin
    sel = SEL_REG;
    if (override) begin
      sel = SEL_SA_IMM;
    end else if (hit_e) begin
      sel = SEL_MALU;
    end else if (hit_m) begin
      sel = SEL_WALU;
    end
  end

endmodule

// File: rtl/pipe_fwd_ctrl.sv
// Forwarding and load-use interlock controller for a 5-stage pipeline: tracks
// EXE/MEM destination shadows and registers ALU A/B selects for the EXE stage.
module pipe_fwd_ctrl
  import pipe_fwd_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  pipe_fwd_ctrl_if.slave  bus
);

  shadow_t          id_p0;
  shadow_t          e_p1;
  fwd_t             m_p2;
  sel_t             a_sel_p0;
  sel_t             b_sel_p0;
  sel_t             a_sel_p1;
  sel_t             b_sel_p1;
  logic             a_load_p0;
  logic             b_load_p0;
  logic             stall_p0;
  logic             vld_p0;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- ID (p0): decode-side hazard and select evaluation ----
  assign id_p0 = '{wreg: bus.dwreg, m2reg: bus.dm2reg, rn: eff_dest(bus.djal, bus.drn)};

  fwd_sel u_fwd_a (
    .src      (bus.drs),
    .use_src  (bus.duse_rs),
    .override (bus.dshift),
    .e        (e_p1),
    .m        (m_p2),
    .sel      (a_sel_p0),
    .load_hit (a_load_p0)
  );

  fwd_sel u_fwd_b (
    .src      (bus.drt),
    .use_src  (bus.duse_rt),
    .override (bus.daluimm),
    .e        (e_p1),
    .m        (m_p2),
    .sel      (b_sel_p0),
    .load_hit (b_load_p0)
  );

  // A flushed or empty slot cannot stall; the interlock is masked during reset
  assign stall_p0 = !rst && bus.dvalid && !bus.dflush && (a_load_p0 || b_load_p0);
  assign vld_p0   = bus.dvalid && !bus.dflush && !stall_p0;

  // ---- EXE (p1) / MEM (p2) shadow registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      e_p1      <= E_BUBBLE;
      m_p2      <= M_BUBBLE;
      a_sel_p1  <= SEL_REG;
      b_sel_p1  <= SEL_REG;
      vld_p1    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      e_p1     <= vld_p0 ? id_p0 : E_BUBBLE;
      m_p2     <= '{wreg: e_p1.wreg, rn: e_p1.rn};
      a_sel_p1 <= vld_p0 ? a_sel_p0 : SEL_REG;
      b_sel_p1 <= vld_p0 ? b_sel_p0 : SEL_REG;
      vld_p1   <= vld_p0;
      if (stall_p0) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign bus.stall     = stall_p0;
  assign bus.adepend   = a_sel_p1;
  assign bus.bdepend   = b_sel_p1;
  assign bus.ebubble   = !vld_p1;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed scenario bench for pipe_fwd_ctrl: forwarding selects, load-use
// interlock, r0 handling, jal destination, overrides, flush and reset.
module tb_pipe_fwd_ctrl;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  pipe_fwd_ctrl_if f();

  pipe_fwd_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic sh,
                        input logic imm, input logic wr, input logic m2,
                        input logic jal, input logic [4:0] rn);
    f.drs = rs; f.drt = rt; f.duse_rs = urs; f.duse_rt = urt;
    f.dshift = sh; f.daluimm = imm; f.dwreg = wr; f.dm2reg = m2;
    f.djal = jal; f.drn = rn; f.dvalid = 1'b1; f.dflush = 1'b0;
  endtask

  task automatic set_nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1);
    tick();
    tick();
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", f.stall); end
    vecs++; if (f.adepend !== 2'b00) begin errs++; $display("FAIL rst_adepend got %b want 00", f.adepend); end
    vecs++; if (f.bdepend !== 2'b00) begin errs++; $display("FAIL rst_bdepend got %b want 00", f.bdepend); end
    vecs++; if (f.ebubble !== 1'b1) begin errs++; $display("FAIL rst_ebubble got %b want 1", f.ebubble); end
    vecs++; if (f.stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall_cnt got %0d want 0", f.stall_cnt); end
    rst = 1'b0;
    set_nop();
    tick();
    tick();
  endtask

  task automatic test_alu_b2b();
    // add r3,r1,r2
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    tick();
    // add r4,r3,r5
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL b2b_stall got %b want 0", f.stall); end
    tick();
    vecs++; if (f.adepend !== 2'b10) begin errs++; $display("FAIL b2b_adepend got %b want 10", f.adepend); end
    vecs++; if (f.bdepend !== 2'b00) begin errs++; $display("FAIL b2b_bdepend got %b want 00", f.bdepend); end
    vecs++; if (f.ebubble !== 1'b0) begin errs++; $display("FAIL b2b_ebubble got %b want 0", f.ebubble); end
  endtask

  task automatic test_distance_two();
    // add r3,r1,r2 ; nop ; sub r6,r7,r3
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    tick();
    set_nop();
    tick();
    set_id(5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6);
    tick();
    vecs++; if (f.bdepend !== 2'b11) begin errs++; $display("FAIL dist2_bdepend got %b want 11", f.bdepend); end
    vecs++; if (f.adepend !== 2'b00) begin errs++; $display("FAIL dist2_adepend got %b want 00", f.adepend); end
  endtask

  task automatic test_load_use();
    // lw r3,0(r1)
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    tick();
    vecs++; if (f.bdepend !== 2'b01) begin errs++; $display("FAIL lw_bdepend got %b want 01", f.bdepend); end
    // add r4,r3,r3
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    #1;
    vecs++; if (f.stall !== 1'b1) begin errs++; $display("FAIL lu_stall1 got %b want 1", f.stall); end
    tick();
    vecs++; if (f.ebubble !== 1'b1) begin errs++; $display("FAIL lu_ebubble got %b want 1", f.ebubble); end
    vecs++; if (f.adepend !== 2'b00) begin errs++; $display("FAIL lu_bubble_adepend got %b want 00", f.adepend); end
    vecs++; if (f.stall_cnt !== 16'd1) begin errs++; $display("FAIL lu_stall_cnt got %0d want 1", f.stall_cnt); end
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL lu_stall2 got %b want 0", f.stall); end
    tick();
    vecs++; if (f.adepend !== 2'b11) begin errs++; $display("FAIL lu_adepend got %b want 11", f.adepend); end
    vecs++; if (f.bdepend !== 2'b11) begin errs++; $display("FAIL lu_bdepend got %b want 11", f.bdepend); end
    vecs++; if (f.ebubble !== 1'b0) begin errs++; $display("FAIL lu_ebubble2 got %b want 0", f.ebubble); end
    vecs++; if (f.stall_cnt !== 16'd1) begin errs++; $display("FAIL lu_stall_cnt2 got %0d want 1", f.stall_cnt); end
  endtask

  task automatic test_reg0();
    // add r0,r1,r2 ; add r4,r0,r0
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    tick();
    vecs++; if (f.adepend !== 2'b00) begin errs++; $display("FAIL r0_adepend got %b want 00", f.adepend); end
    vecs++; if (f.bdepend !== 2'b00) begin errs++; $display("FAIL r0_bdepend got %b want 00", f.bdepend); end
    // lw r0 then use r0 must not stall
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL r0_load_stall got %b want 0", f.stall); end
    tick();
  endtask

  task automatic test_jal();
    // jal with a decoy drn; destination must become r31
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7);
    tick();
    // addu r2,r31,r0
    set_id(5'd31, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
    tick();
    vecs++; if (f.adepend !== 2'b10) begin errs++; $display("FAIL jal_adepend got %b want 10", f.adepend); end
    vecs++; if (f.bdepend !== 2'b00) begin errs++; $display("FAIL jal_bdepend got %b want 00", f.bdepend); end
  endtask

  task automatic test_overrides_flush();
    // add r5 ; sll-style op with dshift and rs/rt = r5 ; addi-style op on r5
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6);
    tick();
    vecs++; if (f.adepend !== 2'b01) begin errs++; $display("FAIL shift_adepend got %b want 01", f.adepend); end
    vecs++; if (f.bdepend !== 2'b10) begin errs++; $display("FAIL shift_bdepend got %b want 10", f.bdepend); end
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7);
    tick();
    vecs++; if (f.adepend !== 2'b11) begin errs++; $display("FAIL imm_adepend got %b want 11", f.adepend); end
    vecs++; if (f.bdepend !== 2'b01) begin errs++; $display("FAIL imm_bdepend got %b want 01", f.bdepend); end
    // lw r8 ; flushed consumer of r8 writing r9 ; next reads r8 and r9
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
    tick();
    set_id(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);
    f.dflush = 1'b1;
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL flush_stall got %b want 0", f.stall); end
    tick();
    vecs++; if (f.ebubble !== 1'b1) begin errs++; $display("FAIL flush_ebubble got %b want 1", f.ebubble); end
    set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10);
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL post_flush_stall got %b want 0", f.stall); end
    tick();
    vecs++; if (f.adepend !== 2'b11) begin errs++; $display("FAIL post_flush_adepend got %b want 11", f.adepend); end
    vecs++; if (f.bdepend !== 2'b00) begin errs++; $display("FAIL post_flush_bdepend got %b want 00", f.bdepend); end
    // dvalid=0 slot also becomes a bubble
    f.dvalid = 1'b0;
    tick();
    vecs++; if (f.ebubble !== 1'b1) begin errs++; $display("FAIL invalid_ebubble got %b want 1", f.ebubble); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    #1;
    vecs++; if (f.stall !== 1'b1) begin errs++; $display("FAIL mid_pre_stall got %b want 1", f.stall); end
    rst = 1'b1;
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL mid_rst_stall got %b want 0", f.stall); end
    tick();
    rst = 1'b0;
    #1;
    vecs++; if (f.stall !== 1'b0) begin errs++; $display("FAIL mid_after_stall got %b want 0", f.stall); end
    vecs++; if (f.stall_cnt !== 16'd0) begin errs++; $display("FAIL mid_stall_cnt got %0d want 0", f.stall_cnt); end
    vecs++; if (f.ebubble !== 1'b1) begin errs++; $display("FAIL mid_ebubble got %b want 1", f.ebubble); end
    tick();
    vecs++; if (f.ebubble !== 1'b0) begin errs++; $display("FAIL mid_issue_ebubble got %b want 0", f.ebubble); end
    vecs++; if (f.adepend !== 2'b00) begin errs++; $display("FAIL mid_adepend got %b want 00", f.adepend); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    set_nop();
    f.dvalid = 1'b0;
    test_reset();
    test_alu_b2b();
    test_distance_two();
    test_load_use();
    test_reg0();
    test_jal();
    test_overrides_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipe_fwd_ctrl.md
PIPE_FWD_CTRL -- requirements
Module: pipe_fwd_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock input 1 (rising edge), then reset input 1 (synchronous, active-high).
REQ-002 The ID-side inputs SHALL be:
- drs, drt: input 5 each; source register numbers.
- duse_rs, duse_rt: input 1 each; instruction reads rs / rt.
- dshift: input 1; ALU A takes sa.
- daluimm: input 1; ALU B takes imm.
- dwreg: input 1; instruction writes a register.
- dm2reg: input 1; instruction is a load.
- djal: input 1; instruction is jal.
- drn: input 5; destination before jal override.
- dvalid: input 1; ID holds a real instruction.
- dflush: input 1; kill ID instruction (taken branch).
REQ-003 The outputs SHALL be:
- stall: output 1; freeze PC and IF/ID, combinational.
- adepend: output 2; registered ALU A select for EXE (00 ea, 01 sa, 10 malu, 11 walu).
- bdepend: output 2; registered ALU B select for EXE (00 eb, 01 imm, 10 malu, 11 walu).
- ebubble: output 1; EXE holds a bubble and the datapath SHALL suppress its write-backs.
- stall_cnt: output 16; saturating count of stall cycles.

Function
REQ-004 Effective destination SHALL be 5'd31 when djal=1, else drn.
REQ-005 The block SHALL keep shadow registers of the EXE and MEM stages: {wreg, m2reg, rn}, advanced every cycle (ID->E, E->M).
REQ-006 Hazard condition: stall SHALL be 1 when all of the following hold:
- dvalid=1, dflush=0;
- E.wreg=1, E.m2reg=1, E.rn!=0;
- (duse_rs and drs==E.rn) or (duse_rt and drt==E.rn).
REQ-007 During a stall, E SHALL load a bubble (wreg=0, m2reg=0, rn=0), ebubble SHALL register 1, and adepend/bdepend SHALL register 00.
REQ-008 When dflush=1 or dvalid=0, E SHALL load a bubble as in REQ-007.
REQ-009 Otherwise adepend SHALL register the following, with first match winning:
- dshift -> 01;
- duse_rs, drs!=0, E.wreg, drs==E.rn -> 10;
- duse_rs, drs!=0, M.wreg, drs==M.rn -> 11;
- else 00.
REQ-010 Otherwise bdepend SHALL register the following, with first match winning:
- daluimm -> 01;
- duse_rt, drt!=0, E.wreg, drt==E.rn -> 10;
- duse_rt, drt!=0, M.wreg, drt==M.rn -> 11;
- else 00.
REQ-011 EXE-stage matches SHALL take priority over MEM-stage matches (most recent producer wins).
REQ-012 Register 0 SHALL never be forwarded or cause a stall.
REQ-013 After a load-use stall, the consumer SHALL see the load in M and select 11 (walu carries the WB write-back value, including load data).
REQ-014 A producer in WB at decode time SHALL be handled by write-before-read in the register file, not by this block.
REQ-015 stall SHALL be purely combinational on the current ID inputs and E shadow state; all other outputs SHALL be registered with latency 1.
REQ-016 stall_cnt SHALL increment on each clock with stall=1 and hold at 16'hFFFF.
REQ-017 Store-data forwarding and multi-cycle units are out of scope.

Reset
REQ-018 On reset=1 at a rising edge, the block SHALL clear:
- E and M shadow registers to bubbles;
- adepend=00, bdepend=00;
- ebubble=1;
- stall_cnt=0.
REQ-019 While reset=1, stall SHALL read 0.
REQ-020 Reset asserted mid-stall SHALL discard the pending stall, with no residual effect on the next cycle.

Structure
REQ-021 Select encodings (SEL_REG=00, SEL_SA_IMM=01, SEL_MALU=10, SEL_WALU=11) and RA=5'd31 SHALL live in the shared pipeline package used by the EXE stage.
REQ-022 One sub-module, fwd_sel, SHALL compute one 2-bit select from (src, use, override, E, M) and SHALL be instantiated for A and B.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- ALU back-to-back: add r3,r1,r2 then add r4,r3,r5 -> adepend=10 for the second instruction, stall=0.
- Distance two: add r3,...; nop; sub r6,r7,r3 -> bdepend=11.
- Load-use: lw r3,0(r1); add r4,r3,r3 -> stall=1 for exactly one cycle, ebubble=1, then adepend=bdepend=11, stall_cnt=1.
- Register 0: add r0,r1,r2; add r4,r0,r0 -> adepend=bdepend=00.
- jal then use: jal target; addu r2,r31,r0 with duse_rs -> adepend=10.
- Overrides and flush: sll with dshift=1 while rs matches E -> adepend=01; dflush=1 on a load-use hazard -> stall=0 and E is a bubble.
